// File: rtl/appliance_cmd_issuer.sv
// appliance_cmd_issuer
//   Initiator for the LD_Project appliance control bus. High-level write
//   commands arrive on a valid/ready port, queue in a small FIFO, and are
//   serialised onto the s0..s5/inp bus one at a time. Each command is held
//   for HOLD_CYCLES clocks and followed by one idle-pattern gap cycle. Washer
//   settings are kept in shadow registers so the parallel washer buses stay
//   stable between commands.
//
// Ports
//   clk, rst            clock (rising edge), synchronous active-high reset
//   req_valid/req_ready command handshake; push when both are high
//   req_dev             00 fridge, 01 AC, 10 washer, 11 illegal (dropped)
//   req_unit            unit select (0 = unit 1, 1 = unit 2)
//   req_field           fridge/AC: {s3,s4}; washer: wash/rinse/spin/cloth
//   req_sub             fridge: fridge/freezer; washer: start; AC: unused
//   req_value           5-bit value
//   s0..s5, inp         serial command bus (idle pattern s0=s1=1, rest 0)
//   wash/rinse/spin/cloth  washer shadow registers
//   busy                FSM active or FIFO holding commands
//   issued_count        completed commands, wraps
module appliance_cmd_issuer #(
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_CYCLES = 1,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_dev,
  input  logic             req_unit,
  input  logic [1:0]       req_field,
  input  logic             req_sub,
  input  logic [4:0]       req_value,
  output logic             s0,
  output logic             s1,
  output logic             s2,
  output logic             s3,
  output logic             s4,
  output logic             s5,
  output logic [4:0]       inp,
  output logic [4:0]       wash,
  output logic [4:0]       rinse,
  output logic [4:0]       spin,
  output logic [4:0]       cloth,
  output logic             busy,
  output logic [CNT_W-1:0] issued_count
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  localparam logic [1:0] DEV_FRIDGE  = 2'b00;
  localparam logic [1:0] DEV_AC      = 2'b01;
  localparam logic [1:0] DEV_WASHER  = 2'b10;
  localparam logic [1:0] DEV_ILLEGAL = 2'b11;

  // Bus word layout: {s0, s1, s2, s3, s4, s5, inp[4:0]}
  localparam logic [10:0] IDLE_BUS = {2'b11, 4'b0000, 5'b00000};

  typedef struct packed {
    logic [1:0] dev;
    logic       unit;
    logic [1:0] field;
    logic       sub;
    logic [4:0] value;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Translate a queued command into the bus word driven while it is held.
  // Washer writes only announce the device/unit on the bus; the value itself
  // lands in the shadow register.
  function automatic logic [10:0] bus_word(input cmd_t c);
    logic [10:0] w;
    w = IDLE_BUS;
    case (c.dev)
      DEV_FRIDGE: w = {c.dev, c.unit, c.field, c.sub, c.value};
      DEV_AC:     w = {c.dev, c.unit, c.field, 1'b0, c.value};
      DEV_WASHER: w = {c.dev, c.unit, c.sub, 1'b0, 1'b0, 5'd0};
      default:    w = IDLE_BUS;
    endcase
    return w;
  endfunction

  cmd_t           mem [FIFO_DEPTH];
  cmd_t           req_cmd;
  cmd_t           head_p0;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    fill;
  logic [AW:0]    fill_nxt;
  logic           empty;
  logic           push_acc;
  logic           push_wr;
  logic           pop;

  state_t         state;
  logic [HW-1:0]  hold_cnt;
  logic [10:0]    bus_p1;

  assign req_cmd  = {req_dev, req_unit, req_field, req_sub, req_value};
  assign empty    = (fill == '0);
  assign push_acc = req_valid && req_ready;
  // Illegal commands complete the handshake but never occupy a slot.
  assign push_wr  = push_acc && (req_dev != DEV_ILLEGAL);
  assign pop      = ((state == IDLE) || (state == GAP)) && !empty;
  assign head_p0  = mem[rd_ptr];

  always_comb begin
    fill_nxt = fill;
    case ({push_wr, pop})
      2'b10:   fill_nxt = fill + (AW+1)'(1);
      2'b01:   fill_nxt = fill - (AW+1)'(1);
      default: fill_nxt = fill;
    endcase
  end

  // Command FIFO storage (data only, never reset)
  always_ff @(posedge clk) begin
    if (push_wr) begin
      mem[wr_ptr] <= req_cmd;
    end
  end

  // FIFO control; req_ready is the registered not-full flag, so a pop in the
  // same cycle cannot open a full FIFO to a push.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fill      <= '0;
      req_ready <= 1'b0;
    end else begin
      if (push_wr) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      fill      <= fill_nxt;
      req_ready <= (fill_nxt != (AW+1)'(FIFO_DEPTH));
    end
  end

  // Stage p0 -> p1: FIFO head decoded into the registered bus and shadows
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      hold_cnt     <= '0;
      bus_p1       <= IDLE_BUS;
      wash         <= 5'd0;
      rinse        <= 5'd0;
      spin         <= 5'd0;
      cloth        <= 5'd0;
      issued_count <= '0;
    end else begin
      case (state)
        IDLE, GAP: begin
          if (pop) begin
            bus_p1   <= bus_word(head_p0);
            hold_cnt <= HW'(HOLD_CYCLES - 1);
            state    <= DRIVE;
            // Shadows move only here, at the pop edge of a washer write.
            if ((head_p0.dev == DEV_WASHER) && !head_p0.sub) begin
              case (head_p0.field)
                2'b00:   wash  <= head_p0.value;
                2'b01:   rinse <= head_p0.value;
                2'b10:   spin  <= head_p0.value;
                default: cloth <= head_p0.value;
              endcase
            end
          end else begin
            bus_p1 <= IDLE_BUS;
            state  <= IDLE;
          end
        end
        DRIVE: begin
          if (hold_cnt == '0) begin
            issued_count <= issued_count + CNT_W'(1);
            bus_p1       <= IDLE_BUS;
            state        <= GAP;
          end else begin
            hold_cnt <= hold_cnt - HW'(1);
          end
        end
        default: begin
          bus_p1 <= IDLE_BUS;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign {s0, s1, s2, s3, s4, s5, inp} = bus_p1;
  assign busy = (state != IDLE) || !empty;

endmodule

// File: tb/tb_appliance_cmd_issuer.sv
module tb_appliance_cmd_issuer;

  localparam int DEPTH = 4;
  localparam int HOLD  = 3;
  localparam int CW    = 8;

  localparam logic [10:0] IDLE_BUS = 11'b11000000000;

  typedef struct packed {
    logic [1:0] dev;
    logic       unit;
    logic [1:0] field;
    logic       sub;
    logic [4:0] value;
  } cmd_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_dev = 2'b00;
  logic          req_unit = 1'b0;
  logic [1:0]    req_field = 2'b00;
  logic          req_sub = 1'b0;
  logic [4:0]    req_value = 5'd0;
  logic          s0, s1, s2, s3, s4, s5;
  logic [4:0]    inp, wash, rinse, spin, cloth;
  logic          busy;
  logic [CW-1:0] issued_count;

  appliance_cmd_issuer #(
    .FIFO_DEPTH (DEPTH),
    .HOLD_CYCLES(HOLD),
    .CNT_W      (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_dev     (req_dev),
    .req_unit    (req_unit),
    .req_field   (req_field),
    .req_sub     (req_sub),
    .req_value   (req_value),
    .s0          (s0),
    .s1          (s1),
    .s2          (s2),
    .s3          (s3),
    .s4          (s4),
    .s5          (s5),
    .inp         (inp),
    .wash        (wash),
    .rinse       (rinse),
    .spin        (spin),
    .cloth       (cloth),
    .busy        (busy),
    .issued_count(issued_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int stall_cycles = 0;

  // Reference model state
  cmd_t          exp_q[$];
  int            starts[$];
  logic [4:0]    m_shadow[4];
  logic [CW-1:0] m_count;
  bit            mon_en = 1'b0;
  bit            in_cmd;
  bit            pending_gap;
  int            beat;
  cmd_t          cur;
  logic [10:0]   mon_bus;

  always @(posedge clk) cyc++;

  // What the bus should show while a command is held, from the device rules.
  function automatic logic [10:0] exp_bus(input cmd_t c);
    logic [10:0] r;
    r = IDLE_BUS;
    if (c.dev == 2'b00)
      r = {1'b0, 1'b0, c.unit, c.field[1], c.field[0], c.sub, c.value};
    else if (c.dev == 2'b01)
      r = {1'b0, 1'b1, c.unit, c.field[1], c.field[0], 1'b0, c.value};
    else if (c.dev == 2'b10 && c.sub)
      r = {1'b1, 1'b0, c.unit, 1'b1, 1'b0, 1'b0, 5'd0};
    else if (c.dev == 2'b10)
      r = {1'b1, 1'b0, c.unit, 1'b0, 1'b0, 1'b0, 5'd0};
    return r;
  endfunction

  function automatic cmd_t rand_cmd(input bit allow_illegal);
    cmd_t c;
    c.dev   = allow_illegal ? 2'($urandom_range(0, 3)) : 2'($urandom_range(0, 2));
    c.unit  = 1'($urandom_range(0, 1));
    c.field = 2'($urandom_range(0, 3));
    c.sub   = 1'($urandom_range(0, 1));
    c.value = 5'($urandom_range(0, 31));
    return c;
  endfunction

  // Scoreboard: every non-idle stretch on the bus must be the next accepted
  // legal command, held HOLD cycles, followed by one idle cycle and a count bump.
  always @(negedge clk) begin
    if (!mon_en) begin
      exp_q.delete();
      in_cmd      = 1'b0;
      pending_gap = 1'b0;
      beat        = 0;
      m_count     = '0;
      for (int k = 0; k < 4; k++) m_shadow[k] = 5'd0;
    end else begin
      mon_bus = {s0, s1, s2, s3, s4, s5, inp};
      if (in_cmd) begin
        checks++;
        if (mon_bus !== exp_bus(cur)) begin
          errors++;
          $display("FAIL hold_beat %0d: bus=%b expected=%b", beat, mon_bus, exp_bus(cur));
        end
        beat++;
      end else if (pending_gap) begin
        pending_gap = 1'b0;
        checks++;
        if (mon_bus !== IDLE_BUS) begin
          errors++;
          $display("FAIL gap_idle: bus=%b expected=%b", mon_bus, IDLE_BUS);
        end
        checks++;
        if (issued_count !== m_count) begin
          errors++;
          $display("FAIL issued_count: got=%0d expected=%0d", issued_count, m_count);
        end
      end else if (mon_bus !== IDLE_BUS) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: bus=%b with no command pending", mon_bus);
        end else begin
          cur = exp_q.pop_front();
          if (cur.dev == 2'b10 && !cur.sub) m_shadow[cur.field] = cur.value;
          starts.push_back(cyc);
          if (mon_bus !== exp_bus(cur)) begin
            errors++;
            $display("FAIL first_beat: bus=%b expected=%b", mon_bus, exp_bus(cur));
          end
          in_cmd = 1'b1;
          beat   = 1;
        end
      end
      if (in_cmd && beat == HOLD) begin
        in_cmd      = 1'b0;
        pending_gap = 1'b1;
        m_count     = m_count + CW'(1);
      end
      checks++;
      if ({wash, rinse, spin, cloth} !== {m_shadow[0], m_shadow[1], m_shadow[2], m_shadow[3]}) begin
        errors++;
        $display("FAIL shadows: got=%h expected=%h", {wash, rinse, spin, cloth},
                 {m_shadow[0], m_shadow[1], m_shadow[2], m_shadow[3]});
      end
    end
  end

  task automatic push(input cmd_t c);
    bit ok;
    ok        = 1'b0;
    req_valid = 1'b1;
    {req_dev, req_unit, req_field, req_sub, req_value} = c;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
      stall_cycles++;
    end
    if (ok) begin
      @(posedge clk);
      if (c.dev != 2'b11) exp_q.push_back(c);
      #1;
    end
    req_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: req_ready=%b expected=1", req_ready);
    end
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #2;
      if (exp_q.size() == 0 && !in_cmd && !pending_gap && !busy) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: busy=%b pending=%0d", busy, exp_q.size());
    end
  endtask

  task automatic do_reset();
    mon_en    = 1'b0;
    req_valid = 1'b0;
    rst       = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
  endtask

  task automatic test_reset();
    mon_en    = 1'b0;
    req_valid = 1'b0;
    rst       = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({s0, s1, s2, s3, s4, s5, inp} !== IDLE_BUS) begin
      errors++;
      $display("FAIL reset_bus: got=%b expected=%b", {s0, s1, s2, s3, s4, s5, inp}, IDLE_BUS);
    end
    checks++;
    if ({wash, rinse, spin, cloth} !== 20'd0) begin
      errors++;
      $display("FAIL reset_shadows: got=%h expected=0", {wash, rinse, spin, cloth});
    end
    checks++;
    if (issued_count !== '0) begin
      errors++;
      $display("FAIL reset_count: got=%0d expected=0", issued_count);
    end
    checks++;
    if (req_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_busy: ready=%b busy=%b expected 0 0", req_ready, busy);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: got=%b expected=1", req_ready);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_single_fridge();
    cmd_t c;
    logic [CW-1:0] c0;
    c  = '{dev: 2'b00, unit: 1'b0, field: 2'b00, sub: 1'b0, value: 5'b10101};
    c0 = issued_count;
    push(c);
    checks++;
    if ({s0, s1, s2, s3, s4, s5, inp} !== IDLE_BUS) begin
      errors++;
      $display("FAIL latency_early: bus=%b expected idle", {s0, s1, s2, s3, s4, s5, inp});
    end
    for (int i = 0; i < HOLD; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({s0, s1, s2, s3, s4, s5, inp} !== 11'b00000010101) begin
        errors++;
        $display("FAIL fridge_beat %0d: bus=%b expected=00000010101", i, {s0, s1, s2, s3, s4, s5, inp});
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if ({s0, s1, s2, s3, s4, s5, inp} !== IDLE_BUS || issued_count !== c0 + CW'(1)) begin
      errors++;
      $display("FAIL fridge_end: bus=%b count=%0d expected idle count=%0d",
               {s0, s1, s2, s3, s4, s5, inp}, issued_count, c0 + CW'(1));
    end
    wait_drain();
  endtask

  task automatic test_back_to_back();
    logic [CW-1:0] c0;
    c0 = issued_count;
    stall_cycles = 0;
    starts.delete();
    for (int i = 0; i < 6; i++) push(rand_cmd(1'b0));
    wait_drain();
    checks++;
    if (stall_cycles == 0) begin
      errors++;
      $display("FAIL full_stall: stall_cycles=%0d expected >0", stall_cycles);
    end
    checks++;
    if (starts.size() != 6) begin
      errors++;
      $display("FAIL b2b_starts: got=%0d expected=6", starts.size());
    end else begin
      for (int i = 1; i < 6; i++) begin
        checks++;
        if (starts[i] - starts[i-1] != HOLD + 1) begin
          errors++;
          $display("FAIL b2b_period %0d: got=%0d expected=%0d", i, starts[i] - starts[i-1], HOLD + 1);
        end
      end
    end
    checks++;
    if (issued_count !== c0 + CW'(6)) begin
      errors++;
      $display("FAIL b2b_count: got=%0d expected=%0d", issued_count, c0 + CW'(6));
    end
  endtask

  task automatic test_washer();
    logic [CW-1:0] c0;
    c0 = issued_count;
    for (int f = 0; f < 4; f++)
      push('{dev: 2'b10, unit: 1'($urandom_range(0, 1)), field: 2'(f), sub: 1'b0, value: 5'b11111});
    push('{dev: 2'b10, unit: 1'b0, field: 2'($urandom_range(0, 3)), sub: 1'b1,
           value: 5'($urandom_range(0, 31))});
    wait_drain();
    checks++;
    if ({wash, rinse, spin, cloth} !== {4{5'b11111}}) begin
      errors++;
      $display("FAIL washer_shadows: got=%h expected=fffff", {wash, rinse, spin, cloth});
    end
    checks++;
    if (issued_count !== c0 + CW'(5)) begin
      errors++;
      $display("FAIL washer_count: got=%0d expected=%0d", issued_count, c0 + CW'(5));
    end
  endtask

  task automatic test_reset_mid_drive();
    bit seen;
    seen = 1'b0;
    push('{dev: 2'b01, unit: 1'b1, field: 2'b10, sub: 1'b0, value: 5'b00100});
    for (int i = 0; i < 20; i++) begin
      if ({s0, s1} == 2'b01) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL ac_drive_seen: bus=%b expected AC beat", {s0, s1, s2, s3, s4, s5, inp});
    end
    mon_en = 1'b0;
    rst    = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({s0, s1, s2, s3, s4, s5, inp} !== IDLE_BUS || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: bus=%b busy=%b expected idle, busy=0", {s0, s1, s2, s3, s4, s5, inp}, busy);
    end
    checks++;
    if (issued_count !== '0 || {wash, rinse, spin, cloth} !== 20'd0) begin
      errors++;
      $display("FAIL abort_state: count=%0d shadows=%h expected 0 0", issued_count, {wash, rinse, spin, cloth});
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    repeat (HOLD + 2) @(posedge clk);
    #1;
    checks++;
    if (issued_count !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_resume: count=%0d busy=%b expected 0 0", issued_count, busy);
    end
  endtask

  task automatic test_illegal();
    logic [CW-1:0] c0;
    cmd_t c;
    c0 = issued_count;
    c  = rand_cmd(1'b0);
    c.dev = 2'b11;
    push(c);
    for (int i = 0; i < HOLD + 3; i++) begin
      checks++;
      if ({s0, s1, s2, s3, s4, s5, inp} !== IDLE_BUS || busy !== 1'b0) begin
        errors++;
        $display("FAIL illegal_quiet: bus=%b busy=%b expected idle, busy=0", {s0, s1, s2, s3, s4, s5, inp}, busy);
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (issued_count !== c0) begin
      errors++;
      $display("FAIL illegal_count: got=%0d expected=%0d", issued_count, c0);
    end
  endtask

  task automatic test_random();
    logic [CW-1:0] c0;
    int n_legal;
    cmd_t c;
    c0 = issued_count;
    n_legal = 0;
    for (int i = 0; i < 40; i++) begin
      c = rand_cmd(1'b1);
      if (c.dev != 2'b11) n_legal++;
      push(c);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    wait_drain();
    checks++;
    if (issued_count !== c0 + CW'(n_legal)) begin
      errors++;
      $display("FAIL random_count: got=%0d expected=%0d", issued_count, c0 + CW'(n_legal));
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 255; i++) push(rand_cmd(1'b0));
    wait_drain();
    checks++;
    if (issued_count !== 8'd255) begin
      errors++;
      $display("FAIL wrap_255: got=%0d expected=255", issued_count);
    end
    push(rand_cmd(1'b0));
    wait_drain();
    checks++;
    if (issued_count !== 8'd0) begin
      errors++;
      $display("FAIL wrap_0: got=%0d expected=0", issued_count);
    end
  endtask

  initial begin
    test_reset();
    test_single_fridge();
    test_back_to_back();
    test_washer();
    test_reset_mid_drive();
    test_illegal();
    test_random();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule
